// File: rtl/hdmi_rx_analyzer.sv
// HDMI receive analyzer: re-times the pixel stream, tags x/y coordinates and locks onto frame timing.
// Define HDMI_RX_CHECKSUM_EN to add the per-frame frame_sum output.
module hdmi_rx_analyzer #(
  parameter int H_MAX = 2047
) (
  input  logic        hdmi_clk,
  input  logic        rst,
  input  logic        hdmi_de,
  input  logic        hdmi_hs,
  input  logic        hdmi_vs,
  input  logic [7:0]  hdmi_r,
  input  logic [7:0]  hdmi_g,
  input  logic [7:0]  hdmi_b,
  output logic        o_de,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic [10:0] h_active,
  output logic [10:0] v_active,
  output logic [10:0] h_total,
  output logic        locked,
  output logic        frame_done,
  output logic        frame_err,
`ifdef HDMI_RX_CHECKSUM_EN
  output logic [15:0] frame_sum,
`endif
  output logic [1:0]  state_dbg
);

  localparam logic [10:0] SAT = 11'(H_MAX);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v >= SAT) ? SAT : v + 11'd1;
  endfunction

  logic       de_q, hs_q, vs_q, de_qq, hs_qq, vs_qq;
  logic [7:0] r_q, g_q, b_q;
  logic       de_rise, de_fall, hs_rise, vs_rise;

  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      {de_q, hs_q, vs_q, de_qq, hs_qq, vs_qq} <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      de_q  <= hdmi_de;
      hs_q  <= hdmi_hs;
      vs_q  <= hdmi_vs;
      r_q   <= hdmi_r;
      g_q   <= hdmi_g;
      b_q   <= hdmi_b;
      de_qq <= de_q;
      hs_qq <= hs_q;
      vs_qq <= vs_q;
    end
  end

  assign de_rise = de_q & ~de_qq;
  assign de_fall = ~de_q & de_qq;
  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;

  // o_de is a valid-only qualifier for o_r/o_g/o_b/o_x/o_y; there is no ready, the stream cannot stall.
  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      o_de <= 1'b0;
      o_r  <= '0;
      o_g  <= '0;
      o_b  <= '0;
      o_x  <= '0;
      o_y  <= '0;
    end else begin
      o_de <= de_q;
      if (de_q) begin
        o_r <= r_q;
        o_g <= g_q;
        o_b <= b_q;
      end
      if (de_rise)   o_x <= '0;
      else if (de_q) o_x <= sat_inc(o_x);
      if (vs_rise)      o_y <= '0;
      else if (de_fall) o_y <= sat_inc(o_y);
    end
  end

  logic [10:0] clk_cnt, h_period, h_period_nxt, px_cnt, first_w, line_cnt;
  logic        line_mm;

  // A stalled hs counter means the period is at least H_MAX, so the measurement saturates.
  always_comb begin
    h_period_nxt = h_period;
    if (hs_rise)             h_period_nxt = sat_inc(clk_cnt);
    else if (clk_cnt == SAT) h_period_nxt = SAT;
  end

  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      clk_cnt  <= '0;
      h_period <= '0;
      px_cnt   <= '0;
      first_w  <= '0;
      line_cnt <= '0;
      line_mm  <= 1'b0;
    end else begin
      clk_cnt  <= hs_rise ? '0 : sat_inc(clk_cnt);
      h_period <= h_period_nxt;
      if (de_rise)   px_cnt <= 11'd1;
      else if (de_q) px_cnt <= sat_inc(px_cnt);
      if (vs_rise) begin
        line_cnt <= '0;
        first_w  <= '0;
        line_mm  <= 1'b0;
      end else if (de_fall) begin
        line_cnt <= sat_inc(line_cnt);
        if (line_cnt == '0)         first_w <= px_cnt;
        else if (px_cnt != first_w) line_mm <= 1'b1;
      end
    end
  end

  logic frame_ok, frame_same;
  assign frame_ok   = (first_w != '0) && (line_cnt != '0) && !line_mm;
  assign frame_same = (first_w == h_active) && (line_cnt == v_active) && (h_period_nxt == h_total);

  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      h_active   <= '0;
      v_active   <= '0;
      h_total    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (vs_rise) begin
        case (state)
          SEARCH: state <= MEASURE;
          MEASURE: begin
            frame_done <= 1'b1;
            if (frame_ok) begin
              h_active <= first_w;
              v_active <= line_cnt;
              h_total  <= h_period_nxt;
              locked   <= 1'b1;
              state    <= LOCKED;
            end
          end
          LOCKED: begin
            frame_done <= 1'b1;
            if (line_mm || !frame_same) begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              state     <= MEASURE;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign state_dbg = state;

`ifdef HDMI_RX_CHECKSUM_EN
  logic [15:0] pix_sum;

  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      pix_sum   <= '0;
      frame_sum <= '0;
    end else begin
      if (vs_rise) begin
        pix_sum <= '0;
        if (state != SEARCH) frame_sum <= pix_sum;
      end else if (de_q) begin
        pix_sum <= pix_sum + 16'(r_q) + 16'(g_q) + 16'(b_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_rx_analyzer.sv
// Testbench for hdmi_rx_analyzer: frame generator, frame-level reference model and pixel scoreboard.
module tb_hdmi_rx_analyzer;

  logic        hdmi_clk = 1'b0;
  logic        rst;
  logic        hdmi_de, hdmi_hs, hdmi_vs;
  logic [7:0]  hdmi_r, hdmi_g, hdmi_b;
  logic        o_de;
  logic [7:0]  o_r, o_g, o_b;
  logic [10:0] o_x, o_y, h_active, v_active, h_total;
  logic        locked, frame_done, frame_err;
  logic [1:0]  state_dbg;
`ifdef HDMI_RX_CHECKSUM_EN
  logic [15:0] frame_sum;
`endif

  hdmi_rx_analyzer dut (
    .hdmi_clk(hdmi_clk), .rst(rst),
    .hdmi_de(hdmi_de), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs),
    .hdmi_r(hdmi_r), .hdmi_g(hdmi_g), .hdmi_b(hdmi_b),
    .o_de(o_de), .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_x(o_x), .o_y(o_y),
    .h_active(h_active), .v_active(v_active), .h_total(h_total),
    .locked(locked), .frame_done(frame_done), .frame_err(frame_err),
`ifdef HDMI_RX_CHECKSUM_EN
    .frame_sum(frame_sum),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 hdmi_clk = ~hdmi_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: frame-level lock behaviour
  int          m_mode;    // 0 searching, 1 measuring, 2 locked
  int          m_ha, m_va, m_ht;
  bit          m_locked;
  logic [15:0] m_fsum;
  int          p_w, p_lines, p_h;
  bit          p_mm;
  logic [15:0] p_sum;

  // scoreboard: {special, chk_xy, de, r, g, b, x, y}
  logic [48:0] exp_q[$];
  logic [23:0] held_rgb;
  bit          skip_xy;
  bit          const_px;
  int          line_w[$];

  task automatic model_reset();
    m_mode = 0; m_ha = 0; m_va = 0; m_ht = 0; m_locked = 0; m_fsum = '0;
    held_rgb = '0;
    exp_q.delete();
  endtask

  task automatic check_zero_outputs();
    check("rst_pix", {o_de, o_r, o_g, o_b, o_x, o_y}, '0);
    check("rst_stat", {h_active, v_active, h_total, locked, frame_done, frame_err, state_dbg}, '0);
`ifdef HDMI_RX_CHECKSUM_EN
    check("rst_sum", frame_sum, '0);
`endif
  endtask

  task automatic frame_edge_check();
    bit e_done = 0;
    bit e_err  = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else begin
      e_done = 1;
      m_fsum = p_sum;
      if (m_mode == 1) begin
        if (p_lines > 0 && p_w > 0 && !p_mm) begin
          m_ha = p_w; m_va = p_lines; m_ht = p_h; m_locked = 1; m_mode = 2;
        end
      end else if (p_mm || p_w != m_ha || p_lines != m_va || p_h != m_ht) begin
        e_err = 1; m_locked = 0; m_mode = 1;
      end
    end
    check("frame_done", frame_done, e_done);
    check("frame_err", frame_err, e_err);
    check("locked", locked, m_locked);
    check("h_active", h_active, m_ha);
    check("v_active", v_active, m_va);
    check("h_total", h_total, m_ht);
`ifdef HDMI_RX_CHECKSUM_EN
    check("frame_sum", frame_sum, m_fsum);
`endif
  endtask

  task automatic pop_and_compare();
    logic [48:0] e;
    e = exp_q.pop_front();
    if (e[46]) begin
      held_rgb = e[45:22];
      check(e[48] ? "pix_l5p10" : "pix",
            {o_de, o_r, o_g, o_b, (e[47] ? {o_x, o_y} : 22'd0)},
            {1'b1, e[45:22], (e[47] ? e[21:0] : 22'd0)});
    end else begin
      check("idle_hold", {o_de, o_r, o_g, o_b}, {1'b0, held_rgb});
    end
  endtask

  // driver: one frame; vsync on lines 0-1, active lines from line 3, de from clock 6 of each line
  task automatic drive_frame(input int h_tot, input int n_total, input bit hs_on, input int rst_at);
    int          n_act, w, a, px, i;
    bit          mm, de_now, special;
    logic [7:0]  r, g, b, x5;
    logic [15:0] sum;
    n_act = line_w.size();
    w     = (n_act > 0) ? line_w[0] : 0;
    mm    = 0;
    for (int k = 1; k < n_act; k++) if (line_w[k] != w) mm = 1;
    sum     = '0;
    x5      = 8'($urandom_range(0, 255));
    skip_xy = 0;
    for (int ln = 0; ln < n_total; ln++) begin
      for (int c = 0; c < h_tot; c++) begin
        i = ln * h_tot + c;
        @(negedge hdmi_clk);
        if (i == rst_at + 1) rst = 1'b0;
        if (i == 2) frame_edge_check();
        if (i == 3) begin
          check("done_pulse", frame_done, 1'b0);
          check("err_pulse", frame_err, 1'b0);
        end
        if (exp_q.size() >= 2) pop_and_compare();
        a       = ln - 3;
        px      = c - 6;
        de_now  = (a >= 0) && (a < n_act) && (px >= 0) && (px < ((a >= 0 && a < n_act) ? line_w[a] : 0));
        special = de_now && !const_px && (a == 5) && (px == 10);
        if (const_px) begin
          r = 8'd1; g = 8'd1; b = 8'd1;
        end else if (special) begin
          r = x5; g = x5; b = x5;
        end else begin
          r = 8'($urandom_range(0, 255));
          g = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
        end
        hdmi_de = de_now;
        hdmi_hs = hs_on && (c < 4);
        hdmi_vs = (ln < 2);
        hdmi_r  = r; hdmi_g = g; hdmi_b = b;
        exp_q.push_back({special, ~skip_xy, de_now, r, g, b, 11'(px), 11'(a)});
        if (de_now) sum = sum + 16'(r) + 16'(g) + 16'(b);
        if (i == rst_at) begin
          #2 rst = 1'b1;
          #1 check_zero_outputs();
          model_reset();
          skip_xy = 1;
        end
      end
    end
    p_w = w; p_lines = n_act; p_mm = mm; p_h = hs_on ? h_tot : 2047; p_sum = sum;
  endtask

  task automatic set_lines(input int n, input int w);
    line_w.delete();
    for (int k = 0; k < n; k++) line_w.push_back(w);
  endtask

  initial begin
    int w, n, ht, nf;
    rst = 1'b1;
    hdmi_de = 0; hdmi_hs = 0; hdmi_vs = 0; hdmi_r = 0; hdmi_g = 0; hdmi_b = 0;
    const_px = 0;
    p_w = 0; p_lines = 0; p_h = 0; p_mm = 0; p_sum = '0;
    model_reset();
    repeat (3) @(negedge hdmi_clk);
    check_zero_outputs();
    rst = 1'b0;

    // 64x64 active, 83 clocks/line, 85 lines/frame
    set_lines(64, 64);
    const_px = 1;
    drive_frame(83, 85, 1, -1);
    const_px = 0;
    drive_frame(83, 85, 1, -1);
`ifdef HDMI_RX_CHECKSUM_EN
    check("sum_ones", frame_sum, 16'd12288);
`endif
    line_w[17] = 63;
    drive_frame(83, 85, 1, -1);
    set_lines(64, 64);
    drive_frame(83, 85, 1, -1);
    drive_frame(83, 85, 1, -1);
    drive_frame(83, 85, 1, 20 * 83 + 30);

    // random timings, occasional short line or empty frame
    w = 0; n = 0; ht = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || $urandom_range(0, 1) == 1) begin
        w  = $urandom_range(4, 40);
        n  = $urandom_range(1, 10);
        ht = w + $urandom_range(10, 30);
      end
      nf = (k > 1 && $urandom_range(0, 7) == 0) ? 0 : n;
      set_lines(nf, w);
      if (k > 1 && nf >= 2 && $urandom_range(0, 3) == 0)
        line_w[$urandom_range(0, nf - 1)] = w - 1;
      drive_frame(ht, n + 6, 1, -1);
    end

    // hs held low: line period measurement must saturate
    set_lines(8, 16);
    drive_frame(40, 60, 0, 20 * 40 + 10);
    for (int k = 0; k < 3; k++) drive_frame(40, 60, 0, -1);
    check("h_total_sat", h_total, 11'd2047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
